// File: rtl/rv_float_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_float_pkg                                                         |
// | Shared formats, field geometry, fclass bit indices and FSM states.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rv_float_pkg;

   typedef enum logic [1:0] {
      FMT_HALF   = 2'b00,
      FMT_SINGLE = 2'b01,
      FMT_DOUBLE = 2'b10,
      FMT_QUAD   = 2'b11
   } fmt_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_NORM = 2'd1,
      ST_OUT  = 2'd2
   } state_e;

   localparam int unsigned DATA_W  = 128;
   localparam int unsigned MANT_W  = 112;
   localparam int unsigned EXP_W   = 16;
   localparam int unsigned CLASS_W = 10;

   localparam int unsigned H_EXP_W  = 5;
   localparam int unsigned H_FRAC_W = 10;
   localparam int unsigned S_EXP_W  = 8;
   localparam int unsigned S_FRAC_W = 23;
   localparam int unsigned D_EXP_W  = 11;
   localparam int unsigned D_FRAC_W = 52;
   localparam int unsigned Q_EXP_W  = 15;
   localparam int unsigned Q_FRAC_W = 112;

   localparam int unsigned H_TOT_W = 1 + H_EXP_W + H_FRAC_W;
   localparam int unsigned S_TOT_W = 1 + S_EXP_W + S_FRAC_W;
   localparam int unsigned D_TOT_W = 1 + D_EXP_W + D_FRAC_W;

   localparam logic [EXP_W-1:0] H_BIAS = 16'd15;
   localparam logic [EXP_W-1:0] S_BIAS = 16'd127;
   localparam logic [EXP_W-1:0] D_BIAS = 16'd1023;
   localparam logic [EXP_W-1:0] Q_BIAS = 16'd16383;

   localparam int unsigned CLS_NEG_INF  = 0;
   localparam int unsigned CLS_NEG_NORM = 1;
   localparam int unsigned CLS_NEG_SUB  = 2;
   localparam int unsigned CLS_NEG_ZERO = 3;
   localparam int unsigned CLS_POS_ZERO = 4;
   localparam int unsigned CLS_POS_SUB  = 5;
   localparam int unsigned CLS_POS_NORM = 6;
   localparam int unsigned CLS_POS_INF  = 7;
   localparam int unsigned CLS_SNAN     = 8;
   localparam int unsigned CLS_QNAN     = 9;

endpackage
`default_nettype wire

// File: rtl/rv_float_classify.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_float_classify                                                    |
// | Combinational field extraction, NaN-box check and fclass decode.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rv_float_classify
   import rv_float_pkg::*;
(
   input  fmt_e               i_fmt,
   input  logic [DATA_W-1:0]  i_data,
   output logic               o_sign,
   output logic [EXP_W-1:0]   o_exponent,
   output logic [MANT_W-1:0]  o_mantissa,
   output logic [CLASS_W-1:0] o_class,
   output logic               o_subnormal
);

   logic              w_sign;
   logic [14:0]       w_efield;
   logic              w_eones;
   logic [MANT_W-1:0] w_frac;
   logic [EXP_W-1:0]  w_bias;
   logic              w_boxed;
   logic              w_ezero;
   logic              w_fzero;

   always_comb begin
      w_sign   = 1'b0;
      w_efield = '0;
      w_eones  = 1'b0;
      w_frac   = '0;
      w_bias   = '0;
      w_boxed  = 1'b1;
      case (i_fmt)
         FMT_HALF: begin
            w_sign   = i_data[H_TOT_W-1];
            w_efield = 15'(i_data[H_FRAC_W +: H_EXP_W]);
            w_eones  = &i_data[H_FRAC_W +: H_EXP_W];
            w_frac   = {i_data[H_FRAC_W-1:0], {(MANT_W-H_FRAC_W){1'b0}}};
            w_bias   = H_BIAS;
            w_boxed  = &i_data[DATA_W-1:H_TOT_W];
         end
         FMT_SINGLE: begin
            w_sign   = i_data[S_TOT_W-1];
            w_efield = 15'(i_data[S_FRAC_W +: S_EXP_W]);
            w_eones  = &i_data[S_FRAC_W +: S_EXP_W];
            w_frac   = {i_data[S_FRAC_W-1:0], {(MANT_W-S_FRAC_W){1'b0}}};
            w_bias   = S_BIAS;
            w_boxed  = &i_data[DATA_W-1:S_TOT_W];
         end
         FMT_DOUBLE: begin
            w_sign   = i_data[D_TOT_W-1];
            w_efield = 15'(i_data[D_FRAC_W +: D_EXP_W]);
            w_eones  = &i_data[D_FRAC_W +: D_EXP_W];
            w_frac   = {i_data[D_FRAC_W-1:0], {(MANT_W-D_FRAC_W){1'b0}}};
            w_bias   = D_BIAS;
            w_boxed  = &i_data[DATA_W-1:D_TOT_W];
         end
         default: begin
            w_sign   = i_data[DATA_W-1];
            w_efield = i_data[Q_FRAC_W +: Q_EXP_W];
            w_eones  = &i_data[Q_FRAC_W +: Q_EXP_W];
            w_frac   = i_data[Q_FRAC_W-1:0];
            w_bias   = Q_BIAS;
         end
      endcase
   end

   assign w_ezero = (w_efield == '0);
   assign w_fzero = (w_frac == '0);

   always_comb begin
      o_sign      = w_sign;
      o_exponent  = '0;
      o_mantissa  = w_frac;
      o_class     = '0;
      o_subnormal = 1'b0;
      if (!w_boxed) begin
         // A broken NaN box reads as the canonical quiet NaN
         o_sign             = 1'b0;
         o_mantissa         = {1'b1, {(MANT_W-1){1'b0}}};
         o_class[CLS_QNAN]  = 1'b1;
      end else if (w_eones) begin
         if (w_fzero)
            o_class[w_sign ? CLS_NEG_INF : CLS_POS_INF] = 1'b1;
         else
            o_class[w_frac[MANT_W-1] ? CLS_QNAN : CLS_SNAN] = 1'b1;
      end else if (w_ezero) begin
         if (w_fzero) begin
            o_class[w_sign ? CLS_NEG_ZERO : CLS_POS_ZERO] = 1'b1;
         end else begin
            o_class[w_sign ? CLS_NEG_SUB : CLS_POS_SUB] = 1'b1;
            o_exponent  = 16'd1 - w_bias;
            o_subnormal = 1'b1;
         end
      end else begin
         o_class[w_sign ? CLS_NEG_NORM : CLS_POS_NORM] = 1'b1;
         o_exponent = {1'b0, w_efield} - w_bias;
      end
   end

endmodule
`default_nettype wire

// File: rtl/rv_float_unpack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_float_unpack                                                      |
// | Unpacks a NaN-boxed RISC-V float into sign/exponent/mantissa/class.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rv_float_unpack
   import rv_float_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [1:0]         fmt_i,
   input  logic [DATA_W-1:0]  data_i,
   input  logic               valid_i,
   output logic               ready_o,
   output logic               sign_o,
   output logic [EXP_W-1:0]   exponent_o,
   output logic [MANT_W-1:0]  mantissa_o,
   output logic [CLASS_W-1:0] class_o,
   output logic               valid_o,
   input  logic               ready_i
);

   state_e             r_state;
   state_e             w_state_nxt;
   logic               r_sign;
   logic [EXP_W-1:0]   r_exp;
   logic [MANT_W:0]    r_mant;
   logic [CLASS_W-1:0] r_class;

   logic               w_cls_sign;
   logic [EXP_W-1:0]   w_cls_exp;
   logic [MANT_W-1:0]  w_cls_mant;
   logic [CLASS_W-1:0] w_cls_class;
   logic               w_cls_sub;
   logic               w_accept;
   logic [MANT_W:0]    w_mant_sh;
   logic [EXP_W-1:0]   w_exp_sh;

   rv_float_classify u_classify (
      .i_fmt       (fmt_e'(fmt_i)),
      .i_data      (data_i),
      .o_sign      (w_cls_sign),
      .o_exponent  (w_cls_exp),
      .o_mantissa  (w_cls_mant),
      .o_class     (w_cls_class),
      .o_subnormal (w_cls_sub)
   );

   assign ready_o  = (r_state == ST_IDLE) | ((r_state == ST_OUT) & ready_i);
   assign w_accept = valid_i & ready_o;

   // Coarse 16-bit steps while the top 16 bits are clear keep quad subnormals short
   always_comb begin
      if (r_mant[MANT_W -: 16] == '0) begin
         w_mant_sh = {r_mant[MANT_W-16:0], 16'b0};
         w_exp_sh  = r_exp - 16'd16;
      end else begin
         w_mant_sh = {r_mant[MANT_W-1:0], 1'b0};
         w_exp_sh  = r_exp - 16'd1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept)
               w_state_nxt = w_cls_sub ? ST_NORM : ST_OUT;
         end
         ST_NORM: begin
            if (w_mant_sh[MANT_W])
               w_state_nxt = ST_OUT;
         end
         ST_OUT: begin
            if (w_accept)
               w_state_nxt = w_cls_sub ? ST_NORM : ST_OUT;
            else if (ready_i)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sign  <= 1'b0;
         r_exp   <= '0;
         r_mant  <= '0;
         r_class <= '0;
      end else if (w_accept) begin
         r_sign  <= w_cls_sign;
         r_exp   <= w_cls_exp;
         r_mant  <= {1'b0, w_cls_mant};
         r_class <= w_cls_class;
      end else if (r_state == ST_NORM) begin
         r_mant <= w_mant_sh;
         r_exp  <= w_exp_sh;
      end
   end

   assign valid_o    = (r_state == ST_OUT);
   assign sign_o     = r_sign;
   assign exponent_o = r_exp;
   assign mantissa_o = r_mant[MANT_W-1:0];
   assign class_o    = r_class;

endmodule
`default_nettype wire

// File: tb/tb_rv_float_unpack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rv_float_unpack                                                   |
// | Randomized self-checking bench with a behavioural unpack model.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rv_float_unpack;

   typedef struct {
      logic         s;
      logic [15:0]  e;
      logic [111:0] m;
      logic [9:0]   c;
      int           lat;
      int           acc;
   } exp_t;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [1:0]   fmt_i;
   logic [127:0] data_i;
   logic         valid_i;
   logic         ready_o;
   logic         sign_o;
   logic [15:0]  exponent_o;
   logic [111:0] mantissa_o;
   logic [9:0]   class_o;
   logic         valid_o;
   logic         ready_i;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   bit   mon_en = 1'b0;
   bit   rdy_rand = 1'b0;
   bit   front_seen = 1'b0;
   exp_t q[$];

   rv_float_unpack dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .fmt_i      (fmt_i),
      .data_i     (data_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .sign_o     (sign_o),
      .exponent_o (exponent_o),
      .mantissa_o (mantissa_o),
      .class_o    (class_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic int ew(input int f);
      case (f) 0: return 5; 1: return 8; 2: return 11; default: return 15; endcase
   endfunction
   function automatic int fw(input int f);
      case (f) 0: return 10; 1: return 23; 2: return 52; default: return 112; endcase
   endfunction
   function automatic int bias(input int f);
      return (1 << (ew(f) - 1)) - 1;
   endfunction

   // What the unpacked value must be, derived from the leading-one position
   function automatic exp_t model(input int f, input logic [127:0] d);
      exp_t         r;
      int           tw, e, p, dd;
      logic [127:0] fr;
      logic [111:0] fl;
      r.s = 1'b0; r.e = '0; r.m = '0; r.c = '0; r.lat = 1; r.acc = 0;
      tw = 1 + ew(f) + fw(f);
      if (tw < 128 && (d | ((128'd1 << tw) - 128'd1)) != {128{1'b1}}) begin
         r.c[9] = 1'b1;
         r.m[111] = 1'b1;
         return r;
      end
      r.s = d[tw-1];
      e   = int'((d >> fw(f)) & ((128'd1 << ew(f)) - 128'd1));
      fr  = d & ((128'd1 << fw(f)) - 128'd1);
      fl  = 112'(fr << (112 - fw(f)));
      if (e == (1 << ew(f)) - 1) begin
         r.m = fl;
         if (fr == 0) r.c[r.s ? 0 : 7] = 1'b1;
         else         r.c[fl[111] ? 9 : 8] = 1'b1;
      end else if (e == 0) begin
         if (fr == 0) begin
            r.c[r.s ? 3 : 4] = 1'b1;
         end else begin
            p = 0;
            for (int i = 111; i >= 0; i--) if (fl[i]) begin p = i; break; end
            dd    = 112 - p;
            r.e   = 16'(1 - bias(f) - dd);
            r.m   = fl << dd;
            r.lat = dd / 16 + dd % 16 + 1;
            r.c[r.s ? 2 : 5] = 1'b1;
         end
      end else begin
         r.e = 16'(e - bias(f));
         r.m = fl;
         r.c[r.s ? 1 : 6] = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [127:0] gen(input int f, input int cat);
      logic [127:0] d, emask, fmask;
      int tw;
      d     = {$urandom, $urandom, $urandom, $urandom};
      tw    = 1 + ew(f) + fw(f);
      fmask = (128'd1 << fw(f)) - 128'd1;
      emask = ((128'd1 << ew(f)) - 128'd1) << fw(f);
      case (cat)
         0: d = d & ~emask;
         1: d = (d & ~emask & ~fmask) | (128'd1 << $urandom_range(0, fw(f) - 1));
         2: d = d | emask;
         3: d = (d | emask) & ~fmask;
         4: d = d & ~(emask | fmask);
         default: ;
      endcase
      if (tw < 128) begin
         d = d | ~((128'd1 << tw) - 128'd1);
         if (cat == 5) d[tw + $urandom_range(0, 127 - tw)] = 1'b0;
      end
      return d;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   always @(negedge clk_i) begin
      exp_t ne;
      if (rst_i) begin
         q.delete();
         front_seen = 1'b0;
      end else if (mon_en) begin
         if (valid_o) begin
            if (q.size() == 0) begin
               chk("unexpected_valid", 128'(valid_o), 128'd0);
            end else begin
               chk("sign", 128'(sign_o), 128'(q[0].s));
               chk("exponent", 128'(exponent_o), 128'(q[0].e));
               chk("mantissa", 128'(mantissa_o), 128'(q[0].m));
               chk("class", 128'(class_o), 128'(q[0].c));
               if (!front_seen) begin
                  chk("latency", 128'(cyc - q[0].acc), 128'(q[0].lat));
                  front_seen = 1'b1;
               end
               if (ready_i) begin
                  void'(q.pop_front());
                  front_seen = 1'b0;
               end
            end
            chk("ready_o_out", 128'(ready_o), 128'(ready_i));
         end else begin
            chk("ready_o", 128'(ready_o), 128'(q.size() == 0));
         end
         if (valid_i && ready_o) begin
            ne = model(int'(fmt_i), data_i);
            ne.acc = cyc;
            q.push_back(ne);
         end
      end
   end

   always @(posedge clk_i) begin
      if (rdy_rand) begin
         #1 ready_i = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send(input logic [1:0] f, input logic [127:0] d);
      int n;
      n = 0;
      fmt_i = f; data_i = d; valid_i = 1'b1;
      forever begin
         @(negedge clk_i);
         if (ready_o) break;
         n++;
         if (n > 200) begin
            chk("send_timeout", 128'(ready_o), 128'd1);
            break;
         end
      end
      @(posedge clk_i); #1 valid_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin @(posedge clk_i); n++; end
      #1;
      chk("drain_empty", 128'(q.size()), 128'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t m;
      rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; fmt_i = 2'b00; data_i = '0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      mon_en = 1'b1;
      @(negedge clk_i);
      chk("rst_valid_o", 128'(valid_o), 128'd0);
      chk("rst_ready_o", 128'(ready_o), 128'd1);
      chk("rst_exponent", 128'(exponent_o), 128'd0);
      chk("rst_mantissa", 128'(mantissa_o), 128'd0);
      chk("rst_class", 128'(class_o), 128'd0);
      chk("rst_sign", 128'(sign_o), 128'd0);

      m = model(1, {{96{1'b1}}, 32'h3F80_0000});
      chk("pin_one_exp", 128'(m.e), 128'd0);
      chk("pin_one_class", 128'(m.c), 128'h040);
      chk("pin_one_lat", 128'(m.lat), 128'd1);
      m = model(1, {{96{1'b1}}, 32'h0000_0001});
      chk("pin_sub_exp", 128'(m.e), 128'(16'hFF6B));
      chk("pin_sub_class", 128'(m.c), 128'h020);
      chk("pin_sub_lat", 128'(m.lat), 128'd9);
      m = model(1, {96'd0, 32'h3F80_0000});
      chk("pin_unbox_mant", 128'(m.m), 128'(112'd1 << 111));
      chk("pin_unbox_class", 128'(m.c), 128'h200);
      m = model(3, {16'h7FFF, 112'd1});
      chk("pin_snan_class", 128'(m.c), 128'h100);
      chk("pin_snan_mant", 128'(m.m), 128'd1);
      m = model(3, 128'd1);
      chk("pin_qmin_exp", 128'(m.e), 128'(16'hBF92));
      chk("pin_qmin_lat", 128'(m.lat), 128'd8);

      send(2'b01, {{96{1'b1}}, 32'h3F80_0000});
      send(2'b01, {{96{1'b1}}, 32'h0000_0001});
      send(2'b01, {96'd0, 32'h3F80_0000});
      send(2'b11, {16'h7FFF, 112'd1});
      send(2'b11, 128'd1);
      send(2'b00, {{112{1'b1}}, 16'h8001});
      send(2'b10, {{64{1'b1}}, 64'hFFF0_0000_0000_0000});
      drain();

      // Downstream stall with a second operand waiting
      ready_i = 1'b0;
      send(2'b10, {{64{1'b1}}, 64'h4000_0000_0000_0000});
      fmt_i = 2'b00; data_i = {{112{1'b1}}, 16'h3C00}; valid_i = 1'b1;
      repeat (3) begin
         @(negedge clk_i);
         chk("stall_ready_o", 128'(ready_o), 128'd0);
         chk("stall_valid_o", 128'(valid_o), 128'd1);
      end
      @(posedge clk_i); #1 ready_i = 1'b1;
      @(negedge clk_i);
      chk("stall_accept_ready_o", 128'(ready_o), 128'd1);
      @(posedge clk_i); #1 valid_i = 1'b0;
      drain();

      rdy_rand = 1'b1;
      for (int k = 0; k < 300; k++) begin
         int f;
         f = int'($urandom_range(0, 3));
         send(2'(f), gen(f, int'($urandom_range(0, 7))));
         repeat ($urandom_range(0, 2)) @(posedge clk_i);
         #1;
      end
      rdy_rand = 1'b0;
      @(posedge clk_i); #1 ready_i = 1'b1;
      drain();

      // Reset in the middle of normalizing the smallest quad subnormal
      send(2'b11, 128'd1);
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b1;
      @(posedge clk_i); #1 rst_i = 1'b0;
      @(negedge clk_i);
      chk("midrst_valid_o", 128'(valid_o), 128'd0);
      chk("midrst_ready_o", 128'(ready_o), 128'd1);
      chk("midrst_exponent", 128'(exponent_o), 128'd0);
      chk("midrst_class", 128'(class_o), 128'd0);
      repeat (12) @(posedge clk_i);
      #1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rv_float_unpack.md
RV_FLOAT_UNPACK -- requirements
Module: rv_float_unpack

Interface
REQ-001 SHALL have port clk_i, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port fmt_i, input, 2, format: 00 half, 01 single, 10 double, 11 quad.
REQ-004 SHALL have port data_i, input, 128, packed operand; narrower formats right-aligned and NaN-boxed.
REQ-005 SHALL have port valid_i, input, 1, operand valid.
REQ-006 SHALL have port ready_o, output, 1, operand accepted when valid_i & ready_o.
REQ-007 SHALL have port sign_o, output, 1, operand sign.
REQ-008 SHALL have port exponent_o, output, 16, unbiased two's-complement exponent.
REQ-009 SHALL have port mantissa_o, output, 112, fraction with hidden bit removed, left-aligned at bit 111.
REQ-010 SHALL have port class_o, output, 10, one-hot RISC-V fclass code.
REQ-011 SHALL have port valid_o, output, 1, result valid.
REQ-012 SHALL have port ready_i, input, 1, downstream ready; result consumed when valid_o & ready_i.

Function
REQ-013 SHALL implement states IDLE, NORM and OUT.
REQ-014 SHALL drive ready_o = (IDLE) | (OUT & ready_i).
REQ-015 SHALL, in IDLE, transition on acceptance to NORM for subnormals and to OUT otherwise.
REQ-016 SHALL, in OUT with ready_i, transition to IDLE, or directly to NORM/OUT on a same-cycle new acceptance.
REQ-017 SHALL use these field widths (exp/frac/bias): half 5/10/15, single 8/23/127, double 11/52/1023, quad 15/112/16383.
REQ-018 SHALL treat non-quad operands whose unused upper bits are not all ones as the canonical qNaN (class bit 9, mantissa_o = 1 at bit 111, other bits 0).
REQ-019 SHALL return normals as exponent_o = field - bias and mantissa_o = fraction left-aligned, low bits zero.
REQ-020 SHALL hold a subnormal in a 113-bit register {hidden=0, fraction} with exponent 1 - bias.
REQ-021 SHALL perform one operation per NORM cycle while hidden = 0: if bits [112:97] are zero, shift left 16 and subtract 16; else shift left 1 and subtract 1.
REQ-022 SHALL leave NORM for OUT on the cycle after hidden = 1.
REQ-023 SHALL bypass normalization for zero, infinity and NaN, producing exponent_o = 0 and mantissa_o = raw left-aligned fraction (NaN payload preserved).
REQ-024 SHALL use these class bits: 0 -inf, 1 -normal, 2 -subnormal, 3 -0, 4 +0, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN.
REQ-025 SHALL assert valid_o for non-subnormals in the cycle after acceptance (latency 1).
REQ-026 SHALL assert valid_o for subnormals N+1 cycles after acceptance, where N is the number of shift operations.
REQ-027 SHALL keep all outputs stable while valid_o & !ready_i.
REQ-028 SHALL fit every exponent (quad minimum -16494) in 16 bits without saturation.

Reset
REQ-029 SHALL, with rst_i high at an edge, enter IDLE and drive valid_o, sign_o, exponent_o, mantissa_o and class_o to 0.
REQ-030 SHALL drive ready_o = 1 in the first cycle after reset.
REQ-031 SHALL, on reset during NORM or OUT, discard the in-flight operand with no output produced.

Structure
REQ-032 SHALL import format enum, bias/width constants and class bit indices from shared package rv_float_pkg.
REQ-033 SHALL place field extraction, NaN-box check and classification in combinational sub-module rv_float_classify.

Verification
REQ-034 SHALL cover: fmt=01, data=0xFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_3F80_0000 -> sign 0, exponent 0, mantissa 0, class bit 6, valid_o one cycle later.
REQ-035 SHALL cover: fmt=01, boxed 0x0000_0001 -> 8 NORM cycles (one 16-shift, seven 1-shifts), exponent -149, mantissa 0, class bit 5, valid_o 9 cycles after acceptance.
REQ-036 SHALL cover: fmt=01, upper 96 bits zero, low word 0x3F80_0000 -> class bit 9, mantissa bit 111 only.
REQ-037 SHALL cover: fmt=11, data=0x7FFF_0000_..._0001 -> class bit 8, exponent 0, mantissa_o = 1, latency 1.
REQ-038 SHALL cover: ready_i low for 3 cycles with a second operand pending -> outputs stable, ready_o 0; on ready_i high the second operand is accepted in the same cycle.
REQ-039 SHALL cover: rst_i pulsed during NORM of a quad minimum subnormal -> valid_o 0 and state IDLE on the next cycle, no result emitted.
